decoder_sweep: RTL and testbench
================================

Name: decoder_sweep

Overview:
- Parametrised, registered N-to-2^N one-hot decoder.
- Drives register-file write-enable selection in the datapath.
- Direct mode: decodes a write address, one-cycle latency.
- Sweep mode: walks a single asserted bit across every output, one per cycle, for register-file initialisation/clear. Start/busy/done handshake, stall support.
- MASK_LAST optionally hard-disables the top output (zero register).

Parameters:
- N, 5, address width; out width is 2^N (N >= 1).
- MASK_LAST, 1, 1 = output bit 2^N-1 never asserts and is excluded from the sweep; 0 = all 2^N outputs usable.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  direct-mode decode request.
- in  in  N  direct-mode address.
- sweep_start  in  1  single-cycle request to begin a sweep.
- sweep_hold  in  1  stalls the sweep while high.
- out  out  2^N  registered one-hot (or zero) select.
- out_idx  out  N  index of the asserted out bit; 0 when out is zero.
- busy  out  1  high while in SWEEP.
- done  out  1  one-cycle pulse on the final sweep output.

Behaviour:
- Reset: synchronous, active-high. Next posedge forces out=0, out_idx=0, busy=0, done=0, state=IDLE, sweep counter=0. Reset has priority over every other input.
- Reset mid-sweep: aborts the sweep. No done pulse.
- States: IDLE and SWEEP. L = 2^N-1-MASK_LAST is the last sweep index.

IDLE:
- sweep_start=1: next cycle state=SWEEP, counter=0, busy=1, out=one-hot(0), out_idx=0.
  - sweep_start beats enable in the same cycle; that direct request is dropped.
- Otherwise, enable=1: next cycle out=one-hot(in), out_idx=in. Latency is exactly 1.
- enable=0: next cycle out=0, out_idx=0.
- MASK_LAST=1 and in=2^N-1: out=0, out_idx=0 (write suppressed).

SWEEP:
- enable, in and sweep_start are ignored, including sweep_start while busy. A repeated start has no effect.
- sweep_hold=1 sampled:
  - next cycle out=0, out_idx=0;
  - counter frozen, busy stays 1, done stays 0.
- sweep_hold=0 and counter<L:
  - counter increments;
  - next cycle out=one-hot(counter+1), out_idx=counter+1.
- The cycle in which out=one-hot(L) is shown also has done=1.
  - Sampling edge with hold=0: next cycle state=IDLE, busy=0, done=0, out=0.
  - Hold=1 at that edge: out goes 0 and done goes 0. The next non-held edge completes the transition to IDLE without re-emitting index L.
  - Inputs present in that final cycle are ignored.
- Output ordering: the first non-held SWEEP cycle shows index 0. Each subsequent non-held cycle shows the next index. Total non-held output cycles = L+1.

Invariants:
- out is always zero or exactly one-hot.
- out_idx matches out.
- done implies busy.
- No index is skipped or repeated within a sweep.
- Width generality: N=1 gives 2 outputs. With MASK_LAST=1 the N=1 sweep is a single cycle, start and done on index 0.

Test Plan (N=5, MASK_LAST=1 unless noted):
- Direct decode:
  - enable=1, in=3 -> next cycle out=32'h0000_0008, out_idx=3.
  - enable=0 -> out=0.
  - in=31, enable=1 -> out=0 (masked).
  - With MASK_LAST=0, in=31 -> out=32'h8000_0000.
- Full sweep: pulse sweep_start -> 31 consecutive cycles out=1<<k for k=0..30, busy=1 throughout. done=1 only on out=32'h4000_0000. Next cycle busy=0, out=0.
- Hold: sweep_hold=1 for 2 cycles after index 4 -> out=0 for 2 cycles, then index 5 resumes. done still arrives on index 30, after 33 total SWEEP cycles.
- Simultaneous/ignored requests:
  - sweep_start and enable (in=7) in the same IDLE cycle -> sweep starts at index 0; out bit 7 not asserted next cycle.
  - sweep_start and enable during SWEEP -> no restart, no effect.
- Reset mid-sweep: assert reset at index 10 -> next cycle out=0, busy=0, done never pulses. A direct decode of in=2 afterwards yields 32'h0000_0004.
- Small width N=2, MASK_LAST=0: direct in=0..3 -> 4'b0001, 4'b0010, 4'b0100, 4'b1000. Sweep -> 4 cycles with done on 4'b1000.

Source files
------------

// File: rtl/decoder_sweep.sv
// Registered N-to-2^N one-hot write-enable decoder with a sweep mode.
// Sweep mode walks one asserted bit across all usable outputs to clear or initialise the register file.
module decoder_sweep #(
  parameter int N         = 5,
  parameter bit MASK_LAST = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [N-1:0]      in,
  input  logic              sweep_start,
  input  logic              sweep_hold,
  output logic [2**N-1:0]   out,
  output logic [N-1:0]      out_idx,
  output logic              busy,
  output logic              done
);

  localparam int OUT_W = 2**N;
  localparam int LAST_INT = OUT_W - 1 - int'(MASK_LAST);
  localparam logic [N-1:0] LAST_IDX = LAST_INT[N-1:0];
  localparam logic [N-1:0] TOP_IDX = '1;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SWEEP = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     cnt_q, cnt_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic [N-1:0]     out_idx_q, out_idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             sel_en;
  logic [N-1:0]     sel_idx;
  logic [N-1:0]     cnt_inc;

  assign cnt_inc = cnt_q + N'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_en  = 1'b0;
    sel_idx = '0;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A start request wins over a direct decode in the same cycle.
        if (sweep_start) begin
          state_d = S_SWEEP;
          cnt_d   = '0;
          sel_en  = 1'b1;
          sel_idx = '0;
          done_d  = (LAST_IDX == '0);
        end else if (enable && !(MASK_LAST && (in == TOP_IDX))) begin
          sel_en  = 1'b1;
          sel_idx = in;
        end
      end
      S_SWEEP: begin
        // cnt_q holds the last index shown, so a hold never skips or repeats one.
        if (!sweep_hold) begin
          if (cnt_q < LAST_IDX) begin
            cnt_d   = cnt_inc;
            sel_en  = 1'b1;
            sel_idx = cnt_inc;
            done_d  = (cnt_inc == LAST_IDX);
          end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d    = (state_d == S_SWEEP);
    out_d     = sel_en ? (OUT_W'(1) << sel_idx) : '0;
    out_idx_d = sel_en ? sel_idx : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      out_q     <= '0;
      out_idx_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
      out_idx_q <= out_idx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign out     = out_q;
  assign out_idx = out_idx_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_decoder_sweep.sv
// Self-checking bench: three decoder_sweep instances (N=5 masked, N=5 unmasked, N=2 unmasked)
// driven in lockstep and compared against a queue-of-indices style reference model.
module tb_decoder_sweep;

  logic        clk = 1'b0;
  logic        reset, enable, sweep_start, sweep_hold;
  logic [4:0]  in5;
  logic [1:0]  in2;

  logic [31:0] out_a, out_b;
  logic [3:0]  out_c;
  logic [4:0]  idx_a, idx_b;
  logic [1:0]  idx_c;
  logic        busy_a, busy_b, busy_c, done_a, done_b, done_c;

  int checks = 0;
  int errors = 0;
  int busy_cnt, done_cnt;

  // Reference model state per instance: 0 = N5/mask, 1 = N5/nomask, 2 = N2/nomask.
  int nbits [3] = '{5, 5, 2};
  int mlast [3] = '{1, 0, 0};
  int act   [3];
  int nxt   [3];
  int e_on  [3];
  int e_idx [3];

  assign in2 = in5[1:0];

  always #5 clk = ~clk;

  decoder_sweep #(.N(5), .MASK_LAST(1'b1)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .in(in5), .sweep_start(sweep_start),
    .sweep_hold(sweep_hold), .out(out_a), .out_idx(idx_a), .busy(busy_a), .done(done_a));

  decoder_sweep #(.N(5), .MASK_LAST(1'b0)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .in(in5), .sweep_start(sweep_start),
    .sweep_hold(sweep_hold), .out(out_b), .out_idx(idx_b), .busy(busy_b), .done(done_b));

  decoder_sweep #(.N(2), .MASK_LAST(1'b0)) dut_c (
    .clk(clk), .reset(reset), .enable(enable), .in(in2), .sweep_start(sweep_start),
    .sweep_hold(sweep_hold), .out(out_c), .out_idx(idx_c), .busy(busy_c), .done(done_c));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // A sweep is the list 0..L handed out one entry per non-held edge; the edge after the list
  // runs dry returns to idle.
  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      int last_i, top, a;
      top    = (1 << nbits[i]) - 1;
      last_i = top - mlast[i];
      a      = int'(in5) & top;
      if (reset) begin
        act[i] = 0; e_on[i] = 0; e_idx[i] = 0;
      end else if (act[i] == 0) begin
        if (sweep_start) begin
          act[i] = 1; nxt[i] = 1; e_on[i] = 1; e_idx[i] = 0;
        end else if (enable && !(mlast[i] == 1 && a == top)) begin
          e_on[i] = 1; e_idx[i] = a;
        end else begin
          e_on[i] = 0; e_idx[i] = 0;
        end
      end else if (sweep_hold) begin
        e_on[i] = 0; e_idx[i] = 0;
      end else if (nxt[i] <= last_i) begin
        e_on[i] = 1; e_idx[i] = nxt[i]; nxt[i] = nxt[i] + 1;
      end else begin
        act[i] = 0; e_on[i] = 0; e_idx[i] = 0;
      end
    end
  endtask

  function automatic logic [31:0] exp_out(input int i);
    return (e_on[i] != 0) ? (32'd1 << e_idx[i]) : 32'd0;
  endfunction

  function automatic logic [31:0] exp_done(input int i);
    int last_i;
    last_i = (1 << nbits[i]) - 1 - mlast[i];
    return 32'((act[i] != 0) && (e_on[i] != 0) && (e_idx[i] == last_i));
  endfunction

  task automatic do_cycle();
    model_edge();
    @(posedge clk);
    #1;
    check("a_out",  out_a,          exp_out(0));
    check("a_idx",  32'(idx_a),     32'(e_idx[0]));
    check("a_busy", 32'(busy_a),    32'(act[0]));
    check("a_done", 32'(done_a),    exp_done(0));
    check("b_out",  out_b,          exp_out(1));
    check("b_idx",  32'(idx_b),     32'(e_idx[1]));
    check("b_busy", 32'(busy_b),    32'(act[1]));
    check("b_done", 32'(done_b),    exp_done(1));
    check("c_out",  32'(out_c),     exp_out(2));
    check("c_idx",  32'(idx_c),     32'(e_idx[2]));
    check("c_busy", 32'(busy_c),    32'(act[2]));
    check("c_done", 32'(done_c),    exp_done(2));
    if (busy_a) busy_cnt++;
    if (done_a) done_cnt++;
    sweep_start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      act[i] = 0; nxt[i] = 0; e_on[i] = 0; e_idx[i] = 0;
    end
    reset = 1'b1; enable = 1'b0; sweep_start = 1'b0; sweep_hold = 1'b0; in5 = '0;
    busy_cnt = 0; done_cnt = 0;
    #1;
    do_cycle();
    do_cycle();
    check("reset_out", out_a, 32'd0);
    reset = 1'b0;

    // Direct decode, disable, masked top index
    enable = 1'b1; in5 = 5'd3;
    do_cycle();
    check("direct_3", out_a, 32'h0000_0008);
    enable = 1'b0;
    do_cycle();
    check("disable", out_a, 32'd0);
    enable = 1'b1; in5 = 5'd31;
    do_cycle();
    check("masked_31", out_a, 32'd0);
    check("unmasked_31", out_b, 32'h8000_0000);
    for (int k = 0; k < 4; k++) begin
      in5 = 5'(k);
      do_cycle();
      check("n2_direct", 32'(out_c), 32'd1 << k);
    end
    enable = 1'b0;
    do_cycle();

    // Full sweep
    busy_cnt = 0; done_cnt = 0;
    sweep_start = 1'b1;
    for (int k = 0; k < 36; k++) begin
      do_cycle();
      if (done_a) check("done_on_last", out_a, 32'h4000_0000);
    end
    check("sweep_busy_cycles", 32'(busy_cnt), 32'd31);
    check("sweep_done_count", 32'(done_cnt), 32'd1);

    // Hold for two cycles after index 4
    busy_cnt = 0;
    sweep_start = 1'b1;
    for (int k = 0; k < 5; k++) do_cycle();
    check("hold_pre_idx", 32'(idx_a), 32'd4);
    sweep_hold = 1'b1;
    do_cycle();
    do_cycle();
    sweep_hold = 1'b0;
    do_cycle();
    check("hold_resume", out_a, 32'h0000_0020);
    for (int k = 0; k < 30; k++) do_cycle();
    check("hold_busy_cycles", 32'(busy_cnt), 32'd33);

    // Start beats enable; requests during a sweep are ignored
    sweep_start = 1'b1; enable = 1'b1; in5 = 5'd7;
    do_cycle();
    check("start_beats_enable", out_a, 32'h0000_0001);
    for (int k = 0; k < 3; k++) do_cycle();
    sweep_start = 1'b1;
    do_cycle();
    check("no_restart_idx", 32'(idx_a), 32'd4);
    enable = 1'b0;
    for (int k = 0; k < 30; k++) do_cycle();

    // Reset mid-sweep at index 10
    done_cnt = 0;
    sweep_start = 1'b1;
    for (int k = 0; k < 11; k++) do_cycle();
    check("pre_reset_idx", 32'(idx_a), 32'd10);
    reset = 1'b1;
    do_cycle();
    check("reset_busy", 32'(busy_a), 32'd0);
    reset = 1'b0; enable = 1'b1; in5 = 5'd2;
    do_cycle();
    check("post_reset_direct", out_a, 32'h0000_0004);
    check("reset_no_done", 32'(done_cnt), 32'd0);
    enable = 1'b0;
    do_cycle();

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      reset       = ($urandom_range(0, 59) == 0);
      sweep_start = ($urandom_range(0, 19) == 0);
      sweep_hold  = ($urandom_range(0, 3) == 0);
      enable      = $urandom_range(0, 1) == 1;
      in5         = 5'($urandom);
      do_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
